// File: rtl/fwd_hazard_ctrl_if.sv
// Pipeline-side bundle for fwd_hazard_ctrl: ID read ports, EXE/MEM/WB writer info,
// forwarded operands, stall/bubble controls and debug taps (FSM state, wait counter).
interface fwd_hazard_ctrl_if #(
    parameter int NUM_RD = 2,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [NUM_RD*ADDR_W-1:0] id_rd_addr;
    logic [NUM_RD-1:0]        id_rd_en;
    logic [NUM_RD*DATA_W-1:0] id_rd_data;
    logic [ADDR_W-1:0]        exe_wr_addr;
    logic                     exe_reg_write;
    logic                     exe_mem_read;
    logic                     exe_movsrc;
    logic [DATA_W-1:0]        exe_alu_data;
    logic [DATA_W-1:0]        mov_data;
    logic [ADDR_W-1:0]        mem_wr_addr;
    logic                     mem_reg_write;
    logic                     mem_dm_read;
    // mem_dm_ready: DM load data is valid in the cycle it is high; a load with it
    // low holds EXE/MEM until the first cycle it rises, there is no other handshake.
    logic                     mem_dm_ready;
    logic [DATA_W-1:0]        mem_alu_data;
    logic [DATA_W-1:0]        mem_data;
    logic [ADDR_W-1:0]        wb_wr_addr;
    logic                     wb_reg_write;
    logic [DATA_W-1:0]        wb_data;
    logic [NUM_RD*DATA_W-1:0] fwd_data;
    logic                     stall_id;
    logic                     bubble_exe;
    logic                     stall_back;
    logic [15:0]              stall_cnt;
    logic                     dm_timeout;
    logic                     dbg_state;
    logic [7:0]               dbg_wait_cnt;

    modport master (
        output id_rd_addr, id_rd_en, id_rd_data,
        output exe_wr_addr, exe_reg_write, exe_mem_read, exe_movsrc, exe_alu_data, mov_data,
        output mem_wr_addr, mem_reg_write, mem_dm_read, mem_dm_ready, mem_alu_data, mem_data,
        output wb_wr_addr, wb_reg_write, wb_data,
        input  fwd_data, stall_id, bubble_exe, stall_back, stall_cnt, dm_timeout,
        input  dbg_state, dbg_wait_cnt
    );

    modport slave (
        input  id_rd_addr, id_rd_en, id_rd_data,
        input  exe_wr_addr, exe_reg_write, exe_mem_read, exe_movsrc, exe_alu_data, mov_data,
        input  mem_wr_addr, mem_reg_write, mem_dm_read, mem_dm_ready, mem_alu_data, mem_data,
        input  wb_wr_addr, wb_reg_write, wb_data,
        output fwd_data, stall_id, bubble_exe, stall_back, stall_cnt, dm_timeout,
        output dbg_state, dbg_wait_cnt
    );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// ID-stage operand forwarding (EXE > MEM > [WB] > regfile) plus load-use / DM-wait stall control.
// Define FWD_WB_BYPASS_EN to add the WB stage as the lowest-priority forwarding source.
`ifndef MvRegSrc
`define MvRegSrc 1'b1
`endif
`ifndef ReadEnable
`define ReadEnable 1'b1
`endif
`ifndef WriteEnable
`define WriteEnable 1'b1
`endif

module fwd_hazard_ctrl #(
    parameter int NUM_RD   = 2,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int WAIT_MAX = 15
) (
    input  logic               clk,
    input  logic               rst,
    fwd_hazard_ctrl_if.slave   bus
);
    localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

    typedef enum logic {RUN = 1'b0, WAIT = 1'b1} state_t;

    state_t                   state;
    logic [7:0]               wait_cnt;
    logic [15:0]              stall_cnt_q;
    logic                     timeout_q;
    logic [NUM_RD-1:0]        exe_hit;
    logic [NUM_RD-1:0]        mem_hit;
    logic [NUM_RD*DATA_W-1:0] fwd;
    logic                     load_use;
    logic                     dm_wait;
    logic                     stall_id_int;

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return !((ZERO_REG != 0) && (a == '0));
    endfunction

`ifdef FWD_WB_BYPASS_EN
    logic [NUM_RD-1:0] wb_hit;
`else
    logic unused_wb;
    assign unused_wb = ^{bus.wb_wr_addr, bus.wb_reg_write, bus.wb_data};
`endif

    always_comb begin
        exe_hit = '0;
        mem_hit = '0;
`ifdef FWD_WB_BYPASS_EN
        wb_hit  = '0;
`endif
        fwd     = bus.id_rd_data;
        for (int i = 0; i < NUM_RD; i++) begin
            exe_hit[i] = (bus.id_rd_en[i] == `ReadEnable) && (bus.exe_reg_write == `WriteEnable)
                         && (bus.id_rd_addr[i*ADDR_W +: ADDR_W] == bus.exe_wr_addr)
                         && addr_ok(bus.id_rd_addr[i*ADDR_W +: ADDR_W]);
            mem_hit[i] = (bus.id_rd_en[i] == `ReadEnable) && (bus.mem_reg_write == `WriteEnable)
                         && (bus.id_rd_addr[i*ADDR_W +: ADDR_W] == bus.mem_wr_addr)
                         && addr_ok(bus.id_rd_addr[i*ADDR_W +: ADDR_W]);
`ifdef FWD_WB_BYPASS_EN
            wb_hit[i]  = (bus.id_rd_en[i] == `ReadEnable) && (bus.wb_reg_write == `WriteEnable)
                         && (bus.id_rd_addr[i*ADDR_W +: ADDR_W] == bus.wb_wr_addr)
                         && addr_ok(bus.id_rd_addr[i*ADDR_W +: ADDR_W]);
`endif
            if (exe_hit[i])
                fwd[i*DATA_W +: DATA_W] = (bus.exe_movsrc == `MvRegSrc) ? bus.mov_data : bus.exe_alu_data;
            else if (mem_hit[i])
                fwd[i*DATA_W +: DATA_W] = bus.mem_dm_read ? bus.mem_data : bus.mem_alu_data;
`ifdef FWD_WB_BYPASS_EN
            else if (wb_hit[i])
                fwd[i*DATA_W +: DATA_W] = bus.wb_data;
`endif
        end
    end

    // A matching EXE load cannot supply data yet; the forwarded value for that port is don't-care.
    assign load_use     = (|exe_hit) && bus.exe_mem_read;
    assign dm_wait      = bus.mem_dm_read && (bus.mem_reg_write == `WriteEnable) && !bus.mem_dm_ready;
    assign stall_id_int = rst && (load_use || dm_wait);

    assign bus.fwd_data     = fwd;
    assign bus.stall_id     = stall_id_int;
    assign bus.bubble_exe   = rst && load_use && !dm_wait;
    assign bus.stall_back   = rst && dm_wait;
    assign bus.stall_cnt    = stall_cnt_q;
    assign bus.dm_timeout   = timeout_q;
    assign bus.dbg_state    = state;
    assign bus.dbg_wait_cnt = wait_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RUN;
            wait_cnt    <= '0;
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            if (stall_id_int && (stall_cnt_q != 16'hFFFF))
                stall_cnt_q <= stall_cnt_q + 16'd1;
            case (state)
                RUN: begin
                    if (dm_wait) begin
                        state    <= WAIT;
                        wait_cnt <= '0;
                    end
                end
                WAIT: begin
                    if (bus.mem_dm_ready) begin
                        state <= RUN;
                    end else if (wait_cnt != WAIT_LIM) begin
                        wait_cnt <= wait_cnt + 8'd1;
                        if (wait_cnt + 8'd1 == WAIT_LIM)
                            timeout_q <= 1'b1;
                    end else begin
                        timeout_q <= 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: a vector table for forwarding/hazard decode plus
// hand sequences for DM wait/timeout, reset in WAIT and (with FWD_WB_BYPASS_EN) WB bypass.
module tb_fwd_hazard_ctrl;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    fwd_hazard_ctrl_if #(.NUM_RD(2), .DATA_W(32), .ADDR_W(5)) bus ();

    fwd_hazard_ctrl #(
        .NUM_RD(2), .DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .WAIT_MAX(15)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  a0, a1;
        logic        en0, en1;
        logic [31:0] rd0, rd1;
        logic [4:0]  exe_a;
        logic        exe_w, exe_ld, movsrc;
        logic [31:0] alu, mov;
        logic [4:0]  mem_a;
        logic        mem_w, mem_ld, rdy;
        logic [31:0] mem_alu, mem_d;
        logic [31:0] e0, e1;
        logic [1:0]  chk;
        logic        e_stall, e_bub, e_back, e_state;
    } vec_t;

    vec_t vt[15];
    vec_t base;
    vec_t v;
    logic [15:0] exp_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t x);
        bus.id_rd_addr    = {x.a1, x.a0};
        bus.id_rd_en      = {x.en1, x.en0};
        bus.id_rd_data    = {x.rd1, x.rd0};
        bus.exe_wr_addr   = x.exe_a;
        bus.exe_reg_write = x.exe_w;
        bus.exe_mem_read  = x.exe_ld;
        bus.exe_movsrc    = x.movsrc;
        bus.exe_alu_data  = x.alu;
        bus.mov_data      = x.mov;
        bus.mem_wr_addr   = x.mem_a;
        bus.mem_reg_write = x.mem_w;
        bus.mem_dm_read   = x.mem_ld;
        bus.mem_dm_ready  = x.rdy;
        bus.mem_alu_data  = x.mem_alu;
        bus.mem_data      = x.mem_d;
    endtask

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        bus.wb_wr_addr   = 5'd0;
        bus.wb_reg_write = 1'b0;
        bus.wb_data      = 32'h0;

        base = '{a0: 5'd1, a1: 5'd2, en0: 1'b1, en1: 1'b1, rd0: 32'h1000_0001, rd1: 32'h2000_0002,
                 exe_a: 5'd30, exe_w: 1'b0, exe_ld: 1'b0, movsrc: 1'b0, alu: 32'hE0, mov: 32'hE1,
                 mem_a: 5'd31, mem_w: 1'b0, mem_ld: 1'b0, rdy: 1'b1, mem_alu: 32'hA0, mem_d: 32'hA1,
                 e0: 32'h1000_0001, e1: 32'h2000_0002, chk: 2'b11,
                 e_stall: 1'b0, e_bub: 1'b0, e_back: 1'b0, e_state: 1'b0};

        // EXE beats MEM (ALU result)
        v = base; v.a0 = 5'd3; v.a1 = 5'd9; v.exe_a = 5'd3; v.exe_w = 1; v.alu = 32'h11;
        v.mov = 32'h22; v.mem_a = 5'd3; v.mem_w = 1; v.e0 = 32'h11; vt[0] = v;
        // EXE move source selected
        v.movsrc = 1; v.e0 = 32'h22; vt[1] = v;
        // MEM ALU result
        v = base; v.a0 = 5'd3; v.exe_a = 5'd4; v.exe_w = 1; v.mem_a = 5'd3; v.mem_w = 1;
        v.mem_alu = 32'h33; v.e0 = 32'h33; vt[2] = v;
        // MEM load with data ready
        v.mem_ld = 1; v.mem_d = 32'h44; v.e0 = 32'h44; vt[3] = v;
        // MEM address match without reg_write
        v.mem_w = 0; v.e0 = base.rd0; vt[4] = v;
        // port disabled ignores an EXE match
        v = base; v.a0 = 5'd3; v.en0 = 0; v.exe_a = 5'd3; v.exe_w = 1; vt[5] = v;
        // r0 never forwarded, even from a load
        v = base; v.a0 = 5'd0; v.exe_a = 5'd0; v.exe_w = 1; v.exe_ld = 1; v.mem_a = 5'd0;
        v.mem_w = 1; vt[6] = v;
        // load-use on port 1
        v = base; v.a0 = 5'd3; v.a1 = 5'd5; v.exe_a = 5'd5; v.exe_w = 1; v.exe_ld = 1;
        v.chk = 2'b01; v.e_stall = 1; v.e_bub = 1; vt[7] = v;
        // load reaches MEM with data ready
        v = base; v.a0 = 5'd3; v.a1 = 5'd5; v.exe_a = 5'd7; v.mem_a = 5'd5; v.mem_w = 1;
        v.mem_ld = 1; v.mem_d = 32'hAB; v.e1 = 32'hAB; vt[8] = v;
        // load in EXE without reg_write: no hazard
        v = base; v.a1 = 5'd5; v.exe_a = 5'd5; v.exe_ld = 1; vt[9] = v;
        // load-use on a disabled port
        v = base; v.a1 = 5'd5; v.en1 = 0; v.exe_a = 5'd5; v.exe_w = 1; v.exe_ld = 1; vt[10] = v;
        // DM wait together with load-use: freeze wins
        v = base; v.a1 = 5'd5; v.exe_a = 5'd5; v.exe_w = 1; v.exe_ld = 1; v.mem_a = 5'd20;
        v.mem_w = 1; v.mem_ld = 1; v.rdy = 0; v.chk = 2'b01; v.e_stall = 1; v.e_back = 1;
        vt[11] = v;
        // data arrives, FSM still in WAIT during this cycle
        v = base; v.mem_a = 5'd20; v.mem_w = 1; v.mem_ld = 1; v.rdy = 1; v.e_state = 1; vt[12] = v;
        // not-ready load without reg_write does not stall
        v = base; v.mem_a = 5'd20; v.mem_ld = 1; v.rdy = 0; vt[13] = v;
        // both ports forward the same EXE result
        v = base; v.a0 = 5'd6; v.a1 = 5'd6; v.exe_a = 5'd6; v.exe_w = 1; v.alu = 32'h55;
        v.e0 = 32'h55; v.e1 = 32'h55; vt[14] = v;

        // reset held with a DM wait pending: controls forced low
        rst = 1'b0;
        v = base; v.mem_w = 1; v.mem_ld = 1; v.rdy = 0; apply(v);
        #12;
        chk("rst_stall_id", 32'(bus.stall_id), 32'd0);
        chk("rst_stall_back", 32'(bus.stall_back), 32'd0);
        chk("rst_bubble", 32'(bus.bubble_exe), 32'd0);
        chk("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
        chk("rst_timeout", 32'(bus.dm_timeout), 32'd0);
        chk("rst_fwd0", bus.fwd_data[31:0], base.rd0);
        apply(base);
        @(negedge clk);
        rst = 1'b1;
        #1;

        exp_cnt = 16'd0;
        for (int k = 0; k < 15; k++) begin
            apply(vt[k]);
            #1;
            if (vt[k].chk[0]) chk($sformatf("v%0d_fwd0", k), bus.fwd_data[31:0], vt[k].e0);
            if (vt[k].chk[1]) chk($sformatf("v%0d_fwd1", k), bus.fwd_data[63:32], vt[k].e1);
            chk($sformatf("v%0d_stall_id", k), 32'(bus.stall_id), 32'(vt[k].e_stall));
            chk($sformatf("v%0d_bubble", k), 32'(bus.bubble_exe), 32'(vt[k].e_bub));
            chk($sformatf("v%0d_stall_back", k), 32'(bus.stall_back), 32'(vt[k].e_back));
            chk($sformatf("v%0d_state", k), 32'(bus.dbg_state), 32'(vt[k].e_state));
            chk($sformatf("v%0d_stall_cnt", k), 32'(bus.stall_cnt), 32'(exp_cnt));
            if (vt[k].e_stall) exp_cnt = exp_cnt + 16'd1;
            @(negedge clk);
        end

        // 20 cycles of DM wait with WAIT_MAX=15: timeout after the 16th edge
        v = base; v.mem_a = 5'd12; v.mem_w = 1; v.mem_ld = 1; v.rdy = 0; apply(v);
        #1;
        for (int c = 0; c < 20; c++) begin
            chk($sformatf("w%0d_stall_back", c), 32'(bus.stall_back), 32'd1);
            chk($sformatf("w%0d_timeout", c), 32'(bus.dm_timeout), (c >= 16) ? 32'd1 : 32'd0);
            next_cycle();
        end
        chk("w_wait_cnt_hold", 32'(bus.dbg_wait_cnt), 32'd15);
        chk("w_stall_cnt", 32'(bus.stall_cnt), 32'(exp_cnt) + 32'd20);
        v.rdy = 1; apply(v);
        #1;
        chk("w_ready_stall_back", 32'(bus.stall_back), 32'd0);
        chk("w_ready_stall_id", 32'(bus.stall_id), 32'd0);
        next_cycle();
        chk("w_after_state", 32'(bus.dbg_state), 32'd0);
        chk("w_after_timeout", 32'(bus.dm_timeout), 32'd1);

        // reset in the middle of a wait
        v.rdy = 0; apply(v);
        next_cycle();
        next_cycle();
        next_cycle();
        chk("r_mid_state", 32'(bus.dbg_state), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("r_stall_id", 32'(bus.stall_id), 32'd0);
        chk("r_stall_back", 32'(bus.stall_back), 32'd0);
        chk("r_bubble", 32'(bus.bubble_exe), 32'd0);
        chk("r_stall_cnt", 32'(bus.stall_cnt), 32'd0);
        chk("r_timeout", 32'(bus.dm_timeout), 32'd0);
        chk("r_state", 32'(bus.dbg_state), 32'd0);
        apply(base);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("r_rel_stall_id", 32'(bus.stall_id), 32'd0);
        next_cycle();
        chk("r_rel_state", 32'(bus.dbg_state), 32'd0);
        chk("r_rel_stall_cnt", 32'(bus.stall_cnt), 32'd0);
        chk("r_rel_stall_back", 32'(bus.stall_back), 32'd0);

        // WB writer of r7: forwarded only with the bypass enabled
        v = base; v.a0 = 5'd7; apply(v);
        bus.wb_wr_addr = 5'd7; bus.wb_reg_write = 1'b1; bus.wb_data = 32'h5;
        #1;
`ifdef FWD_WB_BYPASS_EN
        chk("wb_fwd0", bus.fwd_data[31:0], 32'h5);
`else
        chk("wb_fwd0", bus.fwd_data[31:0], base.rd0);
`endif
        bus.wb_reg_write = 1'b0;
        #1;
        chk("wb_off_fwd0", bus.fwd_data[31:0], base.rd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
